// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / Wishbone data) arbiter onto a single memory-side
// Wishbone master, with one outstanding transaction, alternating tie-break and ack timeout.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic                  instr_stb,
  output logic [31:0]           instr,
  output logic                  instr_ack,
  input  logic                  d_cyc,
  input  logic                  d_stb,
  input  logic                  d_wr_en,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wr_data,
  input  logic [3:0]            d_wr_sel,
  output logic                  d_ack,
  output logic                  d_stall,
  output logic [31:0]           d_rd_data,
  output logic                  m_cyc,
  output logic                  m_stb,
  output logic                  m_wr_en,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_wr_data,
  output logic [3:0]            m_wr_sel,
  input  logic                  m_ack,
  input  logic                  m_stall,
  input  logic [31:0]           m_rd_data,
  output logic                  timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]            r_state;
  logic                  r_lastGrantData;
  logic                  r_grantData;
  logic [CNT_W-1:0]      r_waitCnt;
  logic [ADDR_WIDTH-1:0] r_mAddr;
  logic                  r_mWrEn;
  logic [31:0]           r_mWrData;
  logic [3:0]            r_mWrSel;
  logic [31:0]           r_instr;
  logic [31:0]           r_dRdData;
  logic                  r_instrAck;
  logic                  r_dAck;
  logic                  r_timeout;

  logic w_fetchPend;
  logic w_dataPend;
  logic w_grantFetch;
  logic w_grantData;
  logic w_issueAccept;
  logic w_ackTaken;
  logic w_expire;
  logic w_finish;

  // On a tie the side that did not win last time gets the bus.
  assign w_fetchPend   = instr_stb;
  assign w_dataPend    = d_cyc & d_stb;
  assign w_grantFetch  = (r_state == ST_IDLE) && w_fetchPend && (!w_dataPend || r_lastGrantData);
  assign w_grantData   = (r_state == ST_IDLE) && w_dataPend && (!w_fetchPend || !r_lastGrantData);
  assign w_issueAccept = (r_state == ST_ISSUE) && !m_stall;
  assign w_ackTaken    = (w_issueAccept || (r_state == ST_WAIT)) && m_ack;
  assign w_expire      = (r_state == ST_WAIT) && !m_ack && (r_waitCnt == CNT_LAST);
  assign w_finish      = w_ackTaken || w_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_grantFetch || w_grantData) r_state <= ST_ISSUE;
        ST_ISSUE: if (!m_stall) r_state <= m_ack ? ST_RESP : ST_WAIT;
        ST_WAIT:  if (w_finish) r_state <= ST_RESP;
        ST_RESP:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_waitCnt <= r_waitCnt + CNT_W'(1);
    end else begin
      r_waitCnt <= '0;
    end
  end

  // Request attributes are frozen at grant so a requester may drop stb afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastGrantData <= 1'b1;
      r_grantData     <= 1'b0;
      r_mAddr         <= '0;
      r_mWrEn         <= 1'b0;
      r_mWrData       <= '0;
      r_mWrSel        <= '0;
    end else if (w_grantData) begin
      r_lastGrantData <= 1'b1;
      r_grantData     <= 1'b1;
      r_mAddr         <= d_addr;
      r_mWrEn         <= d_wr_en;
      r_mWrData       <= d_wr_data;
      r_mWrSel        <= d_wr_sel;
    end else if (w_grantFetch) begin
      r_lastGrantData <= 1'b0;
      r_grantData     <= 1'b0;
      r_mAddr         <= instr_addr;
      r_mWrEn         <= 1'b0;
      r_mWrData       <= '0;
      r_mWrSel        <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr   <= '0;
      r_dRdData <= '0;
    end else if (w_ackTaken) begin
      if (r_grantData) r_dRdData <= m_rd_data;
      else             r_instr   <= m_rd_data;
    end else if (w_expire) begin
      if (r_grantData) r_dRdData <= 32'hDEAD_BEEF;
      else             r_instr   <= 32'hDEAD_BEEF;
    end
  end

  // These are high only in the single RESP cycle that follows completion or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instrAck <= 1'b0;
      r_dAck     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_instrAck <= w_finish && !r_grantData;
      r_dAck     <= w_finish && r_grantData;
      r_timeout  <= w_expire;
    end
  end

  assign m_cyc     = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign m_stb     = (r_state == ST_ISSUE);
  assign m_wr_en   = r_mWrEn;
  assign m_addr    = r_mAddr;
  assign m_wr_data = r_mWrData;
  assign m_wr_sel  = r_mWrSel;
  assign instr     = r_instr;
  assign instr_ack = r_instrAck;
  assign d_rd_data = r_dRdData;
  assign d_ack     = r_dAck;
  assign d_stall   = w_dataPend && !w_grantData;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline model with randomized requesters
// and memory responder, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] instr_addr = '0;
  logic          instr_stb = 1'b0;
  logic [31:0]   instr;
  logic          instr_ack;
  logic          d_cyc = 1'b0, d_stb = 1'b0, d_wr_en = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wr_data = '0;
  logic [3:0]    d_wr_sel = '0;
  logic          d_ack, d_stall;
  logic [31:0]   d_rd_data;
  logic          m_cyc, m_stb, m_wr_en;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wr_data;
  logic [3:0]    m_wr_sel;
  logic          m_ack = 1'b0, m_stall = 1'b0;
  logic [31:0]   m_rd_data = '0;
  logic          timeout;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_addr(instr_addr), .instr_stb(instr_stb), .instr(instr), .instr_ack(instr_ack),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_wr_en(d_wr_en), .d_addr(d_addr),
    .d_wr_data(d_wr_data), .d_wr_sel(d_wr_sel), .d_ack(d_ack), .d_stall(d_stall),
    .d_rd_data(d_rd_data),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_wr_en(m_wr_en), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_wr_sel(m_wr_sel),
    .m_ack(m_ack), .m_stall(m_stall), .m_rd_data(m_rd_data), .timeout(timeout)
  );

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;

  logic [31:0] mem [256];

  // Transaction timeline: granted at tG, S stall cycles, ack A cycles after acceptance.
  bit          busy, winData, lastData, grantNow, inReset;
  bit          issueC, waitC, respC, ackC, expDStall;
  int          tG, S, A, resp;
  logic [31:0] rdVal, expInstr, expDrd, expWd;
  logic [AW-1:0] expAddr;
  bit          expWe;
  logic [3:0]  expSel;

  bit          fActive, fGranted, fDropped;
  logic [AW-1:0] fAddr;
  bit          dActive, dGranted, dDropped, dWr;
  logic [AW-1:0] dAddr;
  logic [31:0] dWd;
  logic [3:0]  dSel;

  bit          autoReq, spurOn;
  int          forceS, forceA, rstCycles, startCyc;
  bit          reqFetch, reqData, reqDataWr;
  logic [AW-1:0] reqFetchAddr, reqDataAddr;
  logic [31:0] reqDataWd;
  logic [3:0]  reqDataSel;

  int          fAck, dAck, toCyc, stbFirst, stbCount, ackCount;
  logic [3:0]  stbSel;
  logic        stbWe;
  logic [31:0] stbWd;
  logic        stallHist [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nErrors++;
      $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic clearObs();
    fAck = -1; dAck = -1; toCyc = -1; stbFirst = -1; stbCount = 0; ackCount = 0;
    stbSel = '0; stbWe = 1'b0; stbWd = '0;
    for (int k = 0; k < 64; k++) stallHist[k] = 1'b0;
  endtask

  task automatic applyStimulus();
    bit pendF, pendD;
    int r;
    cyc++;
    if (autoReq && rstCycles == 0 && ($urandom % 500) == 0) rstCycles = 1 + int'($urandom % 2);
    grantNow = 0;
    if (rstCycles > 0) begin
      rstCycles--;
      inReset = 1; rst_n = 1'b0;
      busy = 0; expInstr = '0; expDrd = '0; lastData = 1;
      fActive = 0; dActive = 0;
      instr_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
      issueC = 0; waitC = 0; respC = 0; ackC = 0; expDStall = 0;
      m_stall = 1'b0;
      m_ack = spurOn && (($urandom % 2) == 0);
      m_rd_data = $urandom;
    end else begin
      inReset = 0; rst_n = 1'b1;
      if (busy && cyc > resp) begin
        busy = 0;
        if (winData) dActive = 0; else fActive = 0;
      end
      if (!fActive) begin
        if (reqFetch) begin
          fActive = 1; fGranted = 0; fDropped = 0; fAddr = reqFetchAddr;
          reqFetch = 0; startCyc = cyc;
        end else if (autoReq && ($urandom % 3) == 0) begin
          fActive = 1; fGranted = 0; fDropped = 0; fAddr = AW'($urandom);
        end
      end else if (fGranted && autoReq && ($urandom % 4) == 0) begin
        fDropped = 1;
      end
      if (!dActive) begin
        if (reqData) begin
          dActive = 1; dGranted = 0; dDropped = 0; dAddr = reqDataAddr;
          dWr = reqDataWr; dWd = reqDataWd; dSel = reqDataSel;
          reqData = 0; startCyc = cyc;
        end else if (autoReq && ($urandom % 3) == 0) begin
          dActive = 1; dGranted = 0; dDropped = 0; dAddr = AW'($urandom);
          dWr = ($urandom % 2) == 0; dWd = $urandom; dSel = 4'($urandom);
        end
      end else if (dGranted && autoReq && ($urandom % 4) == 0) begin
        dDropped = 1;
      end
      instr_stb = fActive && !fDropped; instr_addr = fAddr;
      d_cyc = dActive && !dDropped; d_stb = d_cyc;
      d_addr = dAddr; d_wr_en = dWr; d_wr_data = dWd; d_wr_sel = dSel;
      pendF = instr_stb; pendD = d_cyc && d_stb;

      if (!busy && (pendF || pendD)) begin
        grantNow = 1;
        winData = pendD && (!pendF || !lastData);
        lastData = winData;
        tG = cyc;
        if (forceS >= 0) S = forceS;
        else S = (($urandom % 4) == 0) ? int'($urandom % 4) : 0;
        r = int'($urandom % 20);
        if (forceA >= 0) A = forceA;
        else if (r == 0) A = 100;
        else if (r == 1) A = TO;
        else if (r == 2) A = TO - 1;
        else A = int'($urandom % 4);
        resp = tG + 2 + S + ((A > TO) ? TO : A);
        busy = 1;
        if (winData) begin
          dGranted = 1; expAddr = dAddr; expWe = dWr; expWd = dWd; expSel = dSel;
          if (dWr) begin
            rdVal = $urandom;
            if (A <= TO)
              for (int b = 0; b < 4; b++)
                if (dSel[b]) mem[dAddr[AW-1:2]][8*b +: 8] = dWd[8*b +: 8];
          end else begin
            rdVal = mem[dAddr[AW-1:2]];
          end
        end else begin
          fGranted = 1; expAddr = fAddr; expWe = 0; expWd = '0; expSel = '0;
          rdVal = mem[fAddr[AW-1:2]];
        end
      end
      expDStall = pendD && !(grantNow && winData);
      issueC = busy && cyc >= tG + 1 && cyc <= tG + 1 + S;
      waitC  = busy && cyc >= tG + 2 + S && cyc < resp;
      respC  = busy && cyc == resp;
      ackC   = busy && A <= TO && cyc == tG + 1 + S + A;
      m_stall = issueC && cyc < tG + 1 + S;
      m_ack = ackC || (!issueC && !waitC && spurOn && ($urandom % 4) == 0);
      m_rd_data = ackC ? rdVal : $urandom;
      if (respC) begin
        if (winData) expDrd = (A > TO) ? 32'hDEADBEEF : rdVal;
        else         expInstr = (A > TO) ? 32'hDEADBEEF : rdVal;
      end
    end
  endtask

  task automatic checkOutput();
    int k;
    check("m_cyc", 32'(m_cyc), 32'(issueC || waitC));
    check("m_stb", 32'(m_stb), 32'(issueC));
    check("instr_ack", 32'(instr_ack), 32'(respC && !winData));
    check("d_ack", 32'(d_ack), 32'(respC && winData));
    check("timeout", 32'(timeout), 32'(respC && A > TO));
    check("instr", instr, expInstr);
    check("d_rd_data", d_rd_data, expDrd);
    check("d_stall", 32'(d_stall), 32'(expDStall));
    if (issueC) begin
      check("m_addr", 32'(m_addr), 32'(expAddr));
      check("m_wr_en", 32'(m_wr_en), 32'(expWe));
      check("m_wr_data", m_wr_data, expWd);
      check("m_wr_sel", 32'(m_wr_sel), 32'(expSel));
    end
    if (inReset) begin
      check("rst_m_addr", 32'(m_addr), 32'd0);
      check("rst_m_wr_en", 32'(m_wr_en), 32'd0);
      check("rst_m_wr_data", m_wr_data, 32'd0);
      check("rst_m_wr_sel", 32'(m_wr_sel), 32'd0);
    end
    if (instr_ack && fAck < 0) fAck = cyc;
    if (d_ack && dAck < 0) dAck = cyc;
    if (timeout && toCyc < 0) toCyc = cyc;
    ackCount += int'(instr_ack) + int'(d_ack);
    if (m_stb) begin
      stbCount++;
      if (stbFirst < 0) begin
        stbFirst = cyc; stbSel = m_wr_sel; stbWe = m_wr_en; stbWd = m_wr_data;
      end
    end
    k = cyc - startCyc;
    if (k >= 0 && k < 64) stallHist[k] = d_stall;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      applyStimulus();
      @(negedge clk);
      checkOutput();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    busy = 0; lastData = 1; expInstr = '0; expDrd = '0; startCyc = 0;
    fActive = 0; dActive = 0; reqFetch = 0; reqData = 0;
    autoReq = 0; spurOn = 0; forceS = 0; forceA = 1;
    clearObs();
    #1 rst_n = 1'b0;
    rstCycles = 2;
    runCycles(2);
    check("rst_instr", instr, 32'd0);
    check("rst_m_cyc", 32'(m_cyc), 32'd0);
    runCycles(1);

    // Single fetch with 1-cycle memory
    mem[4] = 32'h00500093;
    reqFetch = 1; reqFetchAddr = 10'h010;
    clearObs();
    runCycles(12);
    check("t1_stb_latency", 32'(stbFirst - startCyc), 32'd1);
    check("t1_ack_latency", 32'(fAck - startCyc), 32'd3);
    check("t1_instr", instr, 32'h00500093);

    // Data write passes data and lanes through
    reqData = 1; reqDataAddr = 10'h020; reqDataWr = 1;
    reqDataWd = 32'hA5A5A5A5; reqDataSel = 4'b0011;
    clearObs();
    runCycles(12);
    check("t2_wr_en", 32'(stbWe), 32'd1);
    check("t2_wr_sel", 32'(stbSel), 32'h3);
    check("t2_wr_data", stbWd, 32'hA5A5A5A5);
    check("t2_ack_latency", 32'(dAck - startCyc), 32'd3);
    check("t2_no_instr_ack", 32'(fAck), 32'hFFFFFFFF);

    // Simultaneous requests after reset: fetch first, then data
    rstCycles = 2;
    runCycles(3);
    reqFetch = 1; reqFetchAddr = 10'h104;
    reqData = 1; reqDataAddr = 10'h044; reqDataWr = 0; reqDataWd = 32'h0; reqDataSel = 4'hF;
    clearObs();
    runCycles(14);
    check("t3_fetch_ack", 32'(fAck - startCyc), 32'd3);
    check("t3_data_ack", 32'(dAck - startCyc), 32'd7);
    for (int k = 0; k < 5; k++) check("t3_d_stall_hist", 32'(stallHist[k]), (k < 4) ? 32'd1 : 32'd0);

    // Memory stalls three cycles
    forceS = 3; forceA = 1;
    reqFetch = 1; reqFetchAddr = 10'h0C8;
    clearObs();
    runCycles(14);
    check("t4_stb_cycles", 32'(stbCount), 32'd4);
    check("t4_ack_latency", 32'(fAck - startCyc), 32'd6);
    forceS = 0;

    // Memory never acks
    forceA = 100;
    reqData = 1; reqDataAddr = 10'h030; reqDataWr = 0; reqDataWd = 32'h0; reqDataSel = 4'h0;
    clearObs();
    runCycles(22);
    check("t5_ack_latency", 32'(dAck - startCyc), 32'd17);
    check("t5_timeout_with_ack", 32'(toCyc), 32'(dAck));
    check("t5_deadbeef", d_rd_data, 32'hDEADBEEF);

    // Reset in the middle of WAIT
    reqData = 1; reqDataAddr = 10'h0F0; reqDataWr = 0; reqDataWd = 32'h0; reqDataSel = 4'h0;
    clearObs();
    runCycles(5);
    rstCycles = 2;
    runCycles(1);
    check("t6_m_cyc_in_reset", 32'(m_cyc), 32'd0);
    runCycles(1);
    clearObs();
    runCycles(20);
    check("t6_no_ack_after_reset", 32'(ackCount), 32'd0);
    forceA = 1;
    mem[2] = 32'h12345678;
    reqFetch = 1; reqFetchAddr = 10'h008;
    clearObs();
    runCycles(10);
    check("t6_resume_latency", 32'(fAck - startCyc), 32'd3);
    check("t6_resume_instr", instr, 32'h12345678);

    // Randomized traffic, stalls, timeouts, spurious acks and resets
    autoReq = 1; spurOn = 1; forceS = -1; forceA = -1;
    runCycles(3000);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning byte-address width shared by all ports.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning maximum wait cycles for m_ack before abort.
REQ-003 SHALL use one clock; reset is asynchronous and active-low. Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_addr  in  ADDR_WIDTH  fetch byte address.
- instr_stb  in  1  fetch request, held until instr_ack.
- instr  out  32  fetched word.
- instr_ack  out  1  one-cycle fetch completion.
- d_cyc, d_stb, d_wr_en  in  1 each  data Wishbone cycle, strobe, write.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wr_data  in  32  write data.
- d_wr_sel  in  4  byte lanes.
- d_ack  out  1  one-cycle data completion.
- d_stall  out  1  data request not yet accepted.
- d_rd_data  out  32  read data.
- m_cyc, m_stb, m_wr_en  out  1 each  memory-side Wishbone master.
- m_addr  out  ADDR_WIDTH; m_wr_data  out  32; m_wr_sel  out  4.
- m_ack  in  1; m_stall  in  1; m_rd_data  in  32.
- timeout  out  1  one-cycle pulse coincident with an aborted ack.

Function
REQ-004 SHALL implement states IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding at any time.
REQ-005 A requester is pending when instr_stb=1 (fetch) or d_cyc&d_stb=1 (data); SHALL sample pending requests only in IDLE.
REQ-006 On one pending requester in IDLE, SHALL grant it; on both, SHALL grant the one not in register last_grant; SHALL update last_grant on every grant.
REQ-007 On grant, SHALL register m_addr, m_wr_en, m_wr_data, m_wr_sel from the winner (fetch: m_wr_en=0, m_wr_sel=0000, m_wr_data=0) and move to ISSUE.
REQ-008 ISSUE: m_cyc=1, m_stb=1; SHALL stay in ISSUE while m_stall=1; else to WAIT, or directly to RESP if m_ack=1 this cycle.
REQ-009 WAIT: m_cyc=1, m_stb=0; on m_ack=1 SHALL capture m_rd_data into instr (fetch) or d_rd_data (data) and go RESP.
REQ-010 SHALL count cycles spent in WAIT; when count reaches TIMEOUT_CYCLES without m_ack, SHALL load 32'hDEADBEEF into the granted read register, set timeout for the RESP cycle, go RESP.
REQ-011 RESP: m_cyc=0, m_stb=0; SHALL pulse instr_ack or d_ack (granted side only) for exactly one cycle, then go IDLE.
REQ-012 Latency with zero-stall, 1-cycle-ack memory: request visible in IDLE at cycle t -> ack at t+3; minimum 4 cycles between successive grants.
REQ-013 d_stall SHALL be combinational: 1 when d_cyc&d_stb=1 and the data request is not being granted in IDLE this cycle; 0 otherwise.
REQ-014 The non-granted side's read register and ack SHALL hold unchanged; m_ack outside ISSUE/WAIT SHALL be ignored.
REQ-015 A requester dropping stb after grant SHALL NOT abort the transaction; it completes and acks normally.
REQ-016 The write path SHALL pass d_wr_data/d_wr_sel unmodified; d_rd_data is also updated on writes.

Reset
REQ-017 While rst_n=0 (asynchronously, including mid-transaction): state IDLE, all acks, m_cyc, m_stb, m_wr_en, timeout = 0; instr, d_rd_data, m_addr, m_wr_data, m_wr_sel, WAIT counter = 0; last_grant = data (fetch wins first tie).
REQ-018 An in-flight transaction interrupted by reset SHALL be discarded; no ack issued after release.

Verification
REQ-019 Fetch only, instr_addr=0x10, memory word 4 = 0x00500093 -> m_stb at t+1, instr_ack=1 and instr=0x00500093 at t+3.
REQ-020 Data write d_addr=0x20, d_wr_data=0xA5A5A5A5, d_wr_sel=0011 -> m_wr_en=1, m_wr_sel=0011 in ISSUE, d_ack at t+3, instr_ack stays 0.
REQ-021 Simultaneous fetch and data from reset -> fetch granted first (instr_ack), data next (d_ack), d_stall=1 until data grant.
REQ-022 m_stall=1 for 3 cycles in ISSUE -> m_stb held 4 cycles, ack at t+6.
REQ-023 m_ack never asserted -> after 15 WAIT cycles d_rd_data=0xDEADBEEF, d_ack=1, timeout=1 same cycle.
REQ-024 rst_n low in WAIT -> m_cyc=0 immediately; after release no ack, next request serviced normally.
